// File: rtl/bp_pkg.sv
// bp_pkg: shared helpers for the combined direction predictor / target buffer.
package bp_pkg;
  localparam int BP_PC_MAX = 64;
  localparam int BP_CTR_MAX = 8;
  function automatic logic [BP_CTR_MAX-1:0] sat_inc(input logic [BP_CTR_MAX-1:0] c, input int w);
    logic [BP_CTR_MAX-1:0] top;
    top = BP_CTR_MAX'((64'd1 << w) - 64'd1);
    return c == top ? c : c + BP_CTR_MAX'(1);
  endfunction
  function automatic logic [BP_CTR_MAX-1:0] sat_dec(input logic [BP_CTR_MAX-1:0] c, input int w);
    return (c == '0 || w == 0) ? c : c - BP_CTR_MAX'(1);
  endfunction
  function automatic logic pred_msb(input logic [BP_CTR_MAX-1:0] c, input int w);
    return c[w-1];
  endfunction
  function automatic logic [BP_PC_MAX-1:0] idx_of(input logic [BP_PC_MAX-1:0] pc, input int off, input int iw);
    return (pc >> off) & ((64'd1 << iw) - 64'd1);
  endfunction
  function automatic logic [BP_PC_MAX-1:0] tag_of(input logic [BP_PC_MAX-1:0] pc, input int off, input int iw);
    return pc >> (off + iw);
  endfunction
endpackage

// File: rtl/bp_set_lookup.sv
// bp_set_lookup: way compare with first-hit priority; entry is zero on a miss.
module bp_set_lookup #(
  parameter int WAYS = 2,
  parameter int TAG_W = 24,
  parameter int WAY_W = 1,
  parameter type entry_t = logic
) (
  input  entry_t           ways [WAYS],
  input  logic [TAG_W-1:0] tag,
  output logic             hit,
  output logic [WAY_W-1:0] way,
  output entry_t           entry
);
  always_comb begin
    hit = 1'b0;
    way = '0;
    entry = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (ways[w].valid && ways[w].tag == tag) begin
        hit = 1'b1;
        way = WAY_W'(w);
        entry = ways[w];
      end
  end
endmodule

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: set-associative direction counter + target buffer,
// zero-latency lookup and registered resolution update with round-robin fill.
module branch_target_predictor import bp_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int SETS = 64,
  parameter int WAYS = 2,
  parameter int CTR_WIDTH = 2,
  parameter int OFFSET_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] lookup_pc_i,
  output logic                  hit_o,
  output logic                  pred_taken_o,
  output logic [ADDR_WIDTH-1:0] pred_target_o,
  input  logic                  upd_valid_i,
  input  logic [ADDR_WIDTH-1:0] upd_pc_i,
  input  logic                  upd_taken_i,
  input  logic [ADDR_WIDTH-1:0] upd_target_i,
  input  logic                  flush_i
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS - IDX_W;
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic [CTR_WIDTH-1:0]  ctr;
    logic [ADDR_WIDTH-1:0] target;
  } entry_t;
  entry_t mem [SETS][WAYS];
  logic [WAY_W-1:0] rr [SETS];
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic l_hit, u_hit;
  logic [WAY_W-1:0] l_way, u_way, rr_nxt;
  entry_t l_ent, u_ent, u_nxt;
  assign l_idx = IDX_W'(idx_of(BP_PC_MAX'(lookup_pc_i), OFFSET_BITS, IDX_W));
  assign l_tag = TAG_W'(tag_of(BP_PC_MAX'(lookup_pc_i), OFFSET_BITS, IDX_W));
  assign u_idx = IDX_W'(idx_of(BP_PC_MAX'(upd_pc_i), OFFSET_BITS, IDX_W));
  assign u_tag = TAG_W'(tag_of(BP_PC_MAX'(upd_pc_i), OFFSET_BITS, IDX_W));
  bp_set_lookup #(.WAYS(WAYS), .TAG_W(TAG_W), .WAY_W(WAY_W), .entry_t(entry_t)) u_lk_fetch (
    .ways(mem[l_idx]), .tag(l_tag), .hit(l_hit), .way(l_way), .entry(l_ent)
  );
  bp_set_lookup #(.WAYS(WAYS), .TAG_W(TAG_W), .WAY_W(WAY_W), .entry_t(entry_t)) u_lk_upd (
    .ways(mem[u_idx]), .tag(u_tag), .hit(u_hit), .way(u_way), .entry(u_ent)
  );
  assign hit_o = l_hit;
  assign pred_taken_o = l_hit & pred_msb(BP_CTR_MAX'(l_ent.ctr), CTR_WIDTH);
  assign pred_target_o = l_ent.target;
  assign rr_nxt = WAYS == 1 ? '0 : rr[u_idx] + WAY_W'(1);
  always_comb begin
    u_nxt = u_ent;
    u_nxt.ctr = CTR_WIDTH'(upd_taken_i ? sat_inc(BP_CTR_MAX'(u_ent.ctr), CTR_WIDTH)
                                       : sat_dec(BP_CTR_MAX'(u_ent.ctr), CTR_WIDTH));
    u_nxt.target = upd_taken_i ? upd_target_i : u_ent.target;
  end
  // tags and targets are deliberately left uncleared; valid bits gate them
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      for (int s = 0; s < SETS; s++) begin
        rr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          mem[s][w].valid <= 1'b0;
          if (rst) mem[s][w].ctr <= '0;
        end
      end
    end else if (upd_valid_i) begin
      if (u_hit) mem[u_idx][u_way] <= u_nxt;
      else if (upd_taken_i) begin
        mem[u_idx][rr[u_idx]] <= '{valid: 1'b1, tag: u_tag, ctr: CTR_WEAK, target: upd_target_i};
        rr[u_idx] <= rr_nxt;
      end
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: vector table with a scoreboard of expected lookups.
module tb_branch_target_predictor;
  logic clk = 1'b0;
  logic rst, hit_o, pred_taken_o, upd_valid_i, upd_taken_i, flush_i;
  logic [31:0] lookup_pc_i, pred_target_o, upd_pc_i, upd_target_i;
  always #5 clk = ~clk;
  branch_target_predictor #(
    .ADDR_WIDTH(32), .SETS(64), .WAYS(2), .CTR_WIDTH(2), .OFFSET_BITS(2)
  ) dut (
    .clk(clk), .rst(rst), .lookup_pc_i(lookup_pc_i), .hit_o(hit_o),
    .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .flush_i(flush_i)
  );
  typedef struct {
    logic r, f, uv, ut, chk, eh, et;
    logic [31:0] upc, utg, lpc, etg;
  } vec_t;
  typedef struct {
    logic h, t;
    logic [31:0] tg;
    int id;
  } exp_t;
  vec_t tbl [$];
  exp_t sb [$];
  int n_vec = 0, n_err = 0;
  function automatic vec_t mk(input logic r, f, uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utg, lpc, input logic chk, eh, et,
                              input logic [31:0] etg);
    vec_t v;
    v.r = r; v.f = f; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
    v.lpc = lpc; v.chk = chk; v.eh = eh; v.et = et; v.etg = etg;
    return v;
  endfunction
  task automatic apply(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    rst = v.r; flush_i = v.f; upd_valid_i = v.uv; upd_pc_i = v.upc;
    upd_taken_i = v.ut; upd_target_i = v.utg; lookup_pc_i = v.lpc;
    if (v.chk) sb.push_back('{v.eh, v.et, v.etg, id});
    #1;
    if (v.chk) begin
      e = sb.pop_front();
      n_vec++;
      if (hit_o !== e.h || pred_taken_o !== e.t || pred_target_o !== e.tg) begin
        n_err++;
        $display("FAIL vec%0d pc=%h: hit/taken/target got %b/%b/%h, expected %b/%b/%h",
                 e.id, v.lpc, hit_o, pred_taken_o, pred_target_o, e.h, e.t, e.tg);
      end
    end
  endtask
  initial begin
    rst = 1'b1; flush_i = 1'b0; upd_valid_i = 1'b0; upd_pc_i = '0;
    upd_taken_i = 1'b0; upd_target_i = '0; lookup_pc_i = '0;
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), -1);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), -1);
    // reset state: a spread of PCs must all miss
    for (int i = 0; i < 4; i++)
      apply(mk(0, 0, 0, 0, 0, 0, $urandom, 1, 0, 0, 0), 100 + i);
    // cold miss, counter saturation both ways, target kept on not-taken
    tbl.push_back(mk(0, 0, 1, 32'h1004, 1, 32'h2000, 32'h1004, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h1004, 1, 32'h2000, 32'h1004, 1, 1, 1, 32'h2000));
    tbl.push_back(mk(0, 0, 1, 32'h1004, 1, 32'h2000, 32'h1004, 1, 1, 1, 32'h2000));
    tbl.push_back(mk(0, 0, 1, 32'h1004, 1, 32'h2000, 32'h1004, 1, 1, 1, 32'h2000));
    tbl.push_back(mk(0, 0, 1, 32'h1004, 0, 32'hDEAD0, 32'h1004, 1, 1, 1, 32'h2000));
    tbl.push_back(mk(0, 0, 1, 32'h1004, 0, 32'hDEAD0, 32'h1004, 1, 1, 1, 32'h2000));
    tbl.push_back(mk(0, 0, 1, 32'h1004, 0, 32'hDEAD0, 32'h1004, 1, 1, 0, 32'h2000));
    tbl.push_back(mk(0, 0, 1, 32'h1004, 0, 32'hDEAD0, 32'h1004, 1, 1, 0, 32'h2000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h1004, 1, 1, 0, 32'h2000));
    tbl.push_back(mk(0, 0, 1, 32'h1004, 1, 32'h2000, 32'h1004, 1, 1, 0, 32'h2000));
    tbl.push_back(mk(0, 0, 1, 32'h1004, 1, 32'h2000, 32'h1004, 1, 1, 0, 32'h2000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h1004, 1, 1, 1, 32'h2000));
    // not-taken miss allocates nothing
    tbl.push_back(mk(0, 0, 1, 32'h3008, 0, 32'h9000, 32'h3008, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3008, 1, 0, 0, 0));
    // round-robin replacement in set 1
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h0004, 1, 32'hA000, 32'h0004, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h0104, 1, 32'hB000, 32'h0004, 1, 1, 1, 32'hA000));
    tbl.push_back(mk(0, 0, 1, 32'h0204, 1, 32'hC000, 32'h0104, 1, 1, 1, 32'hB000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0004, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0104, 1, 1, 1, 32'hB000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0204, 1, 1, 1, 32'hC000));
    // same-cycle lookup/update returns the old target
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h1004, 1, 32'h2000, 32'h1004, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h1004, 1, 32'h4000, 32'h1004, 1, 1, 1, 32'h2000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h1004, 1, 1, 1, 32'h4000));
    // flush drops a concurrent update and clears round-robin pointers
    tbl.push_back(mk(0, 1, 1, 32'h2010, 1, 32'h5000, 32'h1004, 1, 1, 1, 32'h4000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h2010, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h1004, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h1004, 1, 32'h6000, 32'h1004, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h1004, 1, 1, 1, 32'h6000));
    // reset mid-stream beats a pending update
    tbl.push_back(mk(1, 0, 1, 32'h0204, 1, 32'h7000, 32'h1004, 1, 1, 1, 32'h6000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h1004, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0204, 1, 0, 0, 0));
    foreach (tbl[i]) apply(tbl[i], i);
    // hand sequence: both ways of set 5 filled, then a third taken miss wraps to way 0
    apply(mk(0, 0, 1, 32'h0014, 1, 32'h1110, 32'h0014, 1, 0, 0, 0), 200);
    apply(mk(0, 0, 1, 32'h0114, 1, 32'h2220, 32'h0014, 1, 1, 1, 32'h1110), 201);
    apply(mk(0, 0, 1, 32'h0214, 1, 32'h3330, 32'h0114, 1, 1, 1, 32'h2220), 202);
    apply(mk(0, 0, 1, 32'h0314, 1, 32'h4440, 32'h0214, 1, 1, 1, 32'h3330), 203);
    apply(mk(0, 0, 0, 0, 0, 0, 32'h0114, 1, 0, 0, 0), 204);
    apply(mk(0, 0, 0, 0, 0, 0, 32'h0314, 1, 1, 1, 32'h4440), 205);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
